// File: rtl/lsu_pkg.sv
// lsu_pkg: shared definitions for the load/store unit.
//   - access size encodings on req_size
//   - FSM state encoding
//   - default data-memory geometry (words, index width)
package lsu_pkg;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;
  localparam logic [1:0] SZ_ILL  = 2'b11;

  localparam int LSU_DEPTH = 32;
  localparam int LSU_IDX_W = 5;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LOAD  = 3'd1,
    RMW   = 3'd2,
    STORE = 3'd3,
    ERR   = 3'd4
  } state_t;

endpackage

// File: rtl/lsu_lane_align.sv
// lsu_lane_align: purely combinational lane logic for sub-word accesses.
// Little-endian: byte 0 is bits [7:0].
// Ports:
//   mem_word   in  32  word read from memory
//   lane       in  2   byte address bits [1:0]
//   size       in  2   SZ_BYTE / SZ_HALF / SZ_WORD
//   sext       in  1   loads: 1 sign-extend, 0 zero-extend
//   wdata      in  16  store data (low byte used for byte stores)
//   load_data  out 32  extracted and extended load result
//   store_word out 32  mem_word with the addressed byte/half replaced
module lsu_lane_align
  import lsu_pkg::*;
(
  input  logic [31:0] mem_word,
  input  logic [1:0]  lane,
  input  logic [1:0]  size,
  input  logic        sext,
  input  logic [15:0] wdata,
  output logic [31:0] load_data,
  output logic [31:0] store_word
);

  logic [7:0]  byte_val;
  logic [15:0] half_val;

  assign byte_val = mem_word[{lane, 3'b000} +: 8];
  // Halfwords are 2-byte aligned, so only lane[1] picks the half.
  assign half_val = lane[1] ? mem_word[31:16] : mem_word[15:0];

  always_comb begin
    load_data  = mem_word;
    store_word = mem_word;
    case (size)
      SZ_BYTE: begin
        load_data = {{24{sext & byte_val[7]}}, byte_val};
        store_word[{lane, 3'b000} +: 8] = wdata[7:0];
      end
      SZ_HALF: begin
        load_data = {{16{sext & half_val[15]}}, half_val};
        if (lane[1]) store_word[31:16] = wdata;
        else         store_word[15:0]  = wdata;
      end
      default: begin
        load_data  = mem_word;
        store_word = mem_word;
      end
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// load_store_unit: initiator between the MEM pipeline stage and the data
// memory. Performs word loads/stores, byte/halfword loads with sign/zero
// extension and sub-word stores by read-modify-write.
// The memory writes on posedge and refreshes mem_dout on negedge, so read
// data for an address issued at posedge k is usable at posedge k+1.
//
// Build option: LSU_SUBWORD_EN
//   defined   - byte/halfword loads and read-modify-write stores
//   undefined - only word accesses; sizes 00/01 complete with resp_err
//
// Ports:
//   clk         in   1   clock, all state on posedge
//   reset       in   1   asynchronous active-low reset
//   req_valid   in   1   request present
//   req_ready   out  1   unit can accept (IDLE only), combinational
//   req_we      in   1   1 store, 0 load
//   req_size    in   2   00 byte, 01 half, 10 word, 11 illegal
//   req_sext    in   1   loads: sign-extend
//   req_addr    in   32  byte address
//   req_wdata   in   32  store data
//   resp_valid  out  1   one-cycle completion pulse
//   resp_rdata  out  32  load data; 0 for stores and errors
//   resp_err    out  1   misaligned / out-of-range / illegal size
//   mem_addr    out  32  word index to memory, registered
//   mem_din     out  32  write data to memory, registered
//   mem_we      out  1   write enable to memory, registered
//   mem_dout    in   32  memory read data
//   dbg_state   out  3   current FSM state
//
// Handshake: a request transfers on a posedge where req_valid && req_ready;
// all request fields are latched on that edge and ignored afterwards. The
// requester holds req_valid until it sees req_ready. There is no
// backpressure on the response side: resp_valid is a single-cycle pulse.
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int DEPTH = LSU_DEPTH,
  parameter int IDX_W = LSU_IDX_W
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [1:0]  req_size,
  input  logic        req_sext,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_din,
  output logic        mem_we,
  input  logic [31:0] mem_dout,
  output state_t      dbg_state
);

  state_t      state;
  logic [29:0] req_idx;
  logic        out_of_range;
  logic        acc_err;
  logic        accept;

  assign req_ready = (state == IDLE);
  assign accept    = req_valid && req_ready;
  assign dbg_state = state;

  // Range check: the shift catches indices beyond the index width, the
  // compare covers DEPTH values that are not a power of two.
  assign req_idx      = req_addr[31:2];
  assign out_of_range = ((req_idx >> IDX_W) != '0) || (req_idx >= 30'(DEPTH));

  always_comb begin
    acc_err = out_of_range;
    case (req_size)
      SZ_WORD: if (req_addr[1:0] != 2'b00) acc_err = 1'b1;
`ifdef LSU_SUBWORD_EN
      SZ_HALF: if (req_addr[0]) acc_err = 1'b1;
      SZ_BYTE: ;
`endif
      default: acc_err = 1'b1;
    endcase
  end

`ifdef LSU_SUBWORD_EN
  // Request fields needed after the accept edge.
  logic [1:0]  r_size;
  logic        r_sext;
  logic [1:0]  r_lane;
  logic [15:0] r_wdata;
  logic [31:0] load_data;
  logic [31:0] store_word;

  lsu_lane_align u_lane_align (
    .mem_word   (mem_dout),
    .lane       (r_lane),
    .size       (r_size),
    .sext       (r_sext),
    .wdata      (r_wdata),
    .load_data  (load_data),
    .store_word (store_word)
  );
`else
  logic [31:0] load_data;
  logic        unused_sext;

  // Word-only build: loads return the full memory word.
  assign load_data   = mem_dout;
  assign unused_sext = req_sext;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      resp_valid <= 1'b0;
      resp_err   <= 1'b0;
      resp_rdata <= '0;
      mem_addr   <= '0;
      mem_din    <= '0;
      mem_we     <= 1'b0;
`ifdef LSU_SUBWORD_EN
      r_size     <= SZ_BYTE;
      r_sext     <= 1'b0;
      r_lane     <= 2'b00;
      r_wdata    <= '0;
`endif
    end else begin
      resp_valid <= 1'b0;
      resp_err   <= 1'b0;
      case (state)
        IDLE: begin
          if (accept) begin
`ifdef LSU_SUBWORD_EN
            r_size  <= req_size;
            r_sext  <= req_sext;
            r_lane  <= req_addr[1:0];
            r_wdata <= req_wdata[15:0];
`endif
            if (acc_err) begin
              state <= ERR;
            end else begin
              mem_addr <= {2'b00, req_idx};
              if (!req_we) begin
                state <= LOAD;
              end else if (req_size == SZ_WORD) begin
                mem_din <= req_wdata;
                mem_we  <= 1'b1;
                state   <= STORE;
              end else begin
`ifdef LSU_SUBWORD_EN
                // Sub-word store: read the old word first.
                state <= RMW;
`else
                // Unreachable: sub-word sizes are flagged as errors.
                state <= ERR;
`endif
              end
            end
          end
        end
        LOAD: begin
          resp_valid <= 1'b1;
          resp_rdata <= load_data;
          state      <= IDLE;
        end
`ifdef LSU_SUBWORD_EN
        RMW: begin
          mem_din <= store_word;
          mem_we  <= 1'b1;
          state   <= STORE;
        end
`endif
        STORE: begin
          // Memory commits on this edge (mem_we was high for the cycle).
          mem_we     <= 1'b0;
          resp_valid <= 1'b1;
          resp_rdata <= '0;
          state      <= IDLE;
        end
        ERR: begin
          resp_valid <= 1'b1;
          resp_err   <= 1'b1;
          resp_rdata <= '0;
          state      <= IDLE;
        end
        default: begin
          mem_we <= 1'b0;
          state  <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Directed testbench for load_store_unit with a behavioural data memory
// (write on posedge, read data refreshed on negedge).
module tb_load_store_unit;
  import lsu_pkg::*;

  logic        clk;
  logic        reset;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [1:0]  req_size;
  logic        req_sext;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic [31:0] mem_addr;
  logic [31:0] mem_din;
  logic        mem_we;
  logic [31:0] mem_dout;
  state_t      dbg_state;

  int tests_run;
  int tests_failed;

  logic [31:0] mem [32];

  load_store_unit dut (
    .clk        (clk),
    .reset      (reset),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_we     (req_we),
    .req_size   (req_size),
    .req_sext   (req_sext),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .resp_valid (resp_valid),
    .resp_rdata (resp_rdata),
    .resp_err   (resp_err),
    .mem_addr   (mem_addr),
    .mem_din    (mem_din),
    .mem_we     (mem_we),
    .mem_dout   (mem_dout),
    .dbg_state  (dbg_state)
  );

  // Clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Data memory model
  always @(posedge clk) begin
    if (mem_we) mem[mem_addr[4:0]] <= mem_din;
  end
  always @(negedge clk) begin
    mem_dout <= mem[mem_addr[4:0]];
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      tests_failed++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Drives one request, then tracks the memory port and the response.
  // exp_we_at < 0 means no memory write is expected.
  task automatic run_req(input string tag, input logic we, input logic [1:0] size,
                         input logic sext, input logic [31:0] addr, input logic [31:0] wdata,
                         input int exp_lat, input logic exp_err, input logic [31:0] exp_rdata,
                         input int exp_we_at, input logic [31:0] exp_din);
    int lat;
    int we_cycles;
    int we_at;
    logic [31:0] cap_din;
    logic [31:0] cap_addr;
    logic cap_err;
    logic [31:0] cap_rdata;
    logic cap_ready;
    lat = -1; we_cycles = 0; we_at = -1;
    cap_din = '0; cap_addr = '0; cap_err = 1'b0; cap_rdata = '0; cap_ready = 1'b0;
    @(negedge clk);
    req_valid = 1'b1; req_we = we; req_size = size; req_sext = sext;
    req_addr = addr; req_wdata = wdata;
    @(posedge clk); #1;
    // Scramble fields after the accept edge: the unit must have latched them.
    req_valid = 1'b0; req_we = 1'($urandom_range(0, 1)); req_size = 2'($urandom_range(0, 3));
    req_sext = 1'($urandom_range(0, 1)); req_addr = $urandom; req_wdata = $urandom;
    for (int c = 0; c < 8; c++) begin
      if (mem_we === 1'b1) begin
        we_cycles++;
        if (we_at < 0) begin
          we_at = c; cap_din = mem_din; cap_addr = mem_addr;
        end
      end
      if (resp_valid === 1'b1) begin
        lat = c; cap_err = resp_err; cap_rdata = resp_rdata; cap_ready = req_ready;
        break;
      end
      @(posedge clk); #1;
    end
    chk({tag, ".lat"}, 32'(lat), 32'(exp_lat));
    chk({tag, ".err"}, 32'(cap_err), 32'(exp_err));
    chk({tag, ".rdata"}, cap_rdata, exp_rdata);
    chk({tag, ".ready_at_resp"}, 32'(cap_ready), 32'd1);
    chk({tag, ".we_cycles"}, 32'(we_cycles), (exp_we_at < 0) ? 32'd0 : 32'd1);
    if (exp_we_at >= 0) begin
      chk({tag, ".we_at"}, 32'(we_at), 32'(exp_we_at));
      chk({tag, ".din"}, cap_din, exp_din);
      chk({tag, ".addr"}, cap_addr, {2'b00, addr[31:2]});
    end
    @(posedge clk); #1;
    chk({tag, ".resp_drop"}, 32'({resp_valid, resp_err}), 32'd0);
  endtask

  initial begin
    logic seen_resp;
    tests_run = 0;
    tests_failed = 0;
    for (int i = 0; i < 32; i++) mem[i] = '0;
    mem_dout = '0;
    reset = 1'b0;
    req_valid = 1'b0; req_we = 1'b0; req_size = SZ_WORD; req_sext = 1'b0;
    req_addr = '0; req_wdata = '0;

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst.resp_valid", 32'(resp_valid), 32'd0);
    chk("rst.resp_err", 32'(resp_err), 32'd0);
    chk("rst.resp_rdata", resp_rdata, 32'd0);
    chk("rst.mem_addr", mem_addr, 32'd0);
    chk("rst.mem_din", mem_din, 32'd0);
    chk("rst.mem_we", 32'(mem_we), 32'd0);
    chk("rst.state", 32'(dbg_state), 32'(IDLE));
    chk("rst.ready", 32'(req_ready), 32'd1);
    reset = 1'b1;

    // Word store then word load
    run_req("st_w_0c", 1'b1, SZ_WORD, 1'b0, 32'h0C, 32'hA5A51234, 1, 1'b0, 32'h0, 0, 32'hA5A51234);
    chk("mem3_after_st", mem[3], 32'hA5A51234);
    run_req("ld_w_0c", 1'b0, SZ_WORD, 1'b0, 32'h0C, 32'h0, 1, 1'b0, 32'hA5A51234, -1, 32'h0);
    run_req("st_w_00", 1'b1, SZ_WORD, 1'b0, 32'h00, 32'hCAFEF00D, 1, 1'b0, 32'h0, 0, 32'hCAFEF00D);
    run_req("ld_w_00", 1'b0, SZ_WORD, 1'b1, 32'h00, 32'h0, 1, 1'b0, 32'hCAFEF00D, -1, 32'h0);
    run_req("st_w_7c", 1'b1, SZ_WORD, 1'b0, 32'h7C, 32'h0BADBEEF, 1, 1'b0, 32'h0, 0, 32'h0BADBEEF);
    run_req("ld_w_7c", 1'b0, SZ_WORD, 1'b0, 32'h7C, 32'h0, 1, 1'b0, 32'h0BADBEEF, -1, 32'h0);

    // Error paths: no memory write, zero data
    run_req("err_ld_w_0a", 1'b0, SZ_WORD, 1'b0, 32'h0A, 32'h0, 1, 1'b1, 32'h0, -1, 32'h0);
    run_req("err_st_h_03", 1'b1, SZ_HALF, 1'b0, 32'h03, 32'hFFFF, 1, 1'b1, 32'h0, -1, 32'h0);
    run_req("err_size11", 1'b1, SZ_ILL, 1'b0, 32'h00, 32'h12345678, 1, 1'b1, 32'h0, -1, 32'h0);
    run_req("err_ld_w_80", 1'b0, SZ_WORD, 1'b0, 32'h80, 32'h0, 1, 1'b1, 32'h0, -1, 32'h0);
    run_req("err_st_w_80", 1'b1, SZ_WORD, 1'b0, 32'h80, 32'h55, 1, 1'b1, 32'h0, -1, 32'h0);
    chk("mem0_after_err", mem[0], 32'hCAFEF00D);

`ifdef LSU_SUBWORD_EN
    // Sub-word loads over 0xA5A5F234
    run_req("st_w_0c_b", 1'b1, SZ_WORD, 1'b0, 32'h0C, 32'hA5A5F234, 1, 1'b0, 32'h0, 0, 32'hA5A5F234);
    run_req("ld_b_0d_s", 1'b0, SZ_BYTE, 1'b1, 32'h0D, 32'h0, 1, 1'b0, 32'hFFFFFFF2, -1, 32'h0);
    run_req("ld_b_0c_z", 1'b0, SZ_BYTE, 1'b0, 32'h0C, 32'h0, 1, 1'b0, 32'h00000034, -1, 32'h0);
    run_req("ld_h_0e_z", 1'b0, SZ_HALF, 1'b0, 32'h0E, 32'h0, 1, 1'b0, 32'h0000A5A5, -1, 32'h0);
    run_req("ld_h_0c_s", 1'b0, SZ_HALF, 1'b1, 32'h0C, 32'h0, 1, 1'b0, 32'hFFFFF234, -1, 32'h0);
    // Read-modify-write stores
    run_req("st_b_0f", 1'b1, SZ_BYTE, 1'b0, 32'h0F, 32'h0000007E, 2, 1'b0, 32'h0, 1, 32'h7EA5F234);
    run_req("ld_w_0c_rmw", 1'b0, SZ_WORD, 1'b0, 32'h0C, 32'h0, 1, 1'b0, 32'h7EA5F234, -1, 32'h0);
    run_req("st_h_0c", 1'b1, SZ_HALF, 1'b0, 32'h0C, 32'h1111BEEF, 2, 1'b0, 32'h0, 1, 32'h7EA5BEEF);
    run_req("ld_h_0e_s", 1'b0, SZ_HALF, 1'b1, 32'h0E, 32'h0, 1, 1'b0, 32'h00007EA5, -1, 32'h0);
    chk("mem3_after_rmw", mem[3], 32'h7EA5BEEF);
`else
    // Word-only build: sub-word sizes complete with an error
    run_req("err_ld_b_00", 1'b0, SZ_BYTE, 1'b1, 32'h00, 32'h0, 1, 1'b1, 32'h0, -1, 32'h0);
    run_req("err_ld_h_00", 1'b0, SZ_HALF, 1'b0, 32'h00, 32'h0, 1, 1'b1, 32'h0, -1, 32'h0);
    run_req("err_st_b_0c", 1'b1, SZ_BYTE, 1'b0, 32'h0C, 32'h7E, 1, 1'b1, 32'h0, -1, 32'h0);
    run_req("ld_w_00_again", 1'b0, SZ_WORD, 1'b0, 32'h00, 32'h0, 1, 1'b0, 32'hCAFEF00D, -1, 32'h0);
    chk("mem3_unchanged", mem[3], 32'hA5A51234);
`endif

    // Reset during the STORE cycle of a word store to 0x10
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b1; req_size = SZ_WORD; req_sext = 1'b0;
    req_addr = 32'h10; req_wdata = 32'h11112222;
    @(posedge clk); #1;
    req_valid = 1'b0;
    chk("rst_mid.we_before", 32'(mem_we), 32'd1);
    reset = 1'b0;
    #1;
    chk("rst_mid.we_drop", 32'(mem_we), 32'd0);
    chk("rst_mid.state", 32'(dbg_state), 32'(IDLE));
    seen_resp = 1'b0;
    repeat (3) begin
      @(posedge clk); #1;
      if (resp_valid !== 1'b0) seen_resp = 1'b1;
    end
    chk("rst_mid.no_resp", 32'(seen_resp), 32'd0);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk); #1;
    chk("rst_mid.ready", 32'(req_ready), 32'd1);
    chk("rst_mid.resp_valid", 32'(resp_valid), 32'd0);
    chk("rst_mid.mem4", mem[4], 32'h0);
    run_req("ld_w_10", 1'b0, SZ_WORD, 1'b0, 32'h10, 32'h0, 1, 1'b0, 32'h0, -1, 32'h0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  // Global time limit
  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule
